// File: rtl/aes_pkg.sv
// Shared AES constants, ShiftRows byte-index tables and a byte-extract helper.
package aes_pkg;

  localparam int unsigned AES_STATE_W   = 128;
  localparam int unsigned AES_BYTE_W    = 8;
  localparam int unsigned AES_NUM_BYTES = AES_STATE_W / AES_BYTE_W;

  // Output byte k takes input byte INV_SHIFT_IDX[k] (decrypt direction).
  localparam logic [3:0] INV_SHIFT_IDX [16] = '{
    4'd0,  4'd13, 4'd10, 4'd7,
    4'd4,  4'd1,  4'd14, 4'd11,
    4'd8,  4'd5,  4'd2,  4'd15,
    4'd12, 4'd9,  4'd6,  4'd3
  };

  // Output byte k takes input byte SHIFT_IDX[k] (encrypt direction).
  localparam logic [3:0] SHIFT_IDX [16] = '{
    4'd0,  4'd5,  4'd10, 4'd15,
    4'd4,  4'd9,  4'd14, 4'd3,
    4'd8,  4'd13, 4'd2,  4'd7,
    4'd12, 4'd1,  4'd6,  4'd11
  };

  // Byte k sits at bits [127-8k -: 8], so byte 0 is the most significant.
  function automatic logic [AES_BYTE_W-1:0] aes_get_byte(input logic [AES_STATE_W-1:0] state,
                                                         input logic [3:0]             k);
    logic [AES_STATE_W-1:0] shifted;
    shifted = state << (AES_BYTE_W * k);
    return shifted[AES_STATE_W-1 -: AES_BYTE_W];
  endfunction

endpackage

// File: rtl/inv_shift_row_perm.sv
// Combinational ShiftRows byte permutation; fwd_mode_i = 1 selects the forward order.
module inv_shift_row_perm
  import aes_pkg::*;
(
  input  logic                   fwd_mode_i,
  input  logic [AES_STATE_W-1:0] data_i,
  output logic [AES_STATE_W-1:0] data_o
);

  always_comb begin
    data_o = '0;
    for (int k = 0; k < AES_NUM_BYTES; k++) begin
      data_o[AES_STATE_W-1-AES_BYTE_W*k -: AES_BYTE_W] =
          aes_get_byte(data_i, fwd_mode_i ? SHIFT_IDX[k] : INV_SHIFT_IDX[k]);
    end
  end

endmodule

// File: rtl/inv_shift_row.sv
// InvShiftRows pipeline stage with registered output and a skid register.
// Define INV_SHIFT_ROW_FWD_EN to add the per-beat invShiftRow_fwd_mode input.
module inv_shift_row
  import aes_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = AES_STATE_W
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  invShiftRow_valid_in,
  output logic                  invShiftRow_ready_in,
  input  logic [DATA_WIDTH-1:0] invShiftRow_data_in,
  output logic [DATA_WIDTH-1:0] invShiftRow_data_out,
  output logic                  invShiftRow_valid_out,
`ifdef INV_SHIFT_ROW_FWD_EN
  input  logic                  invShiftRow_fwd_mode,
`endif
  input  logic                  invShiftRow_ready_out
);

  logic                  or_valid_q, or_valid_d;
  logic                  sk_valid_q, sk_valid_d;
  logic [DATA_WIDTH-1:0] or_data_q, or_data_d;
  logic [DATA_WIDTH-1:0] sk_data_q, sk_data_d;
  logic [DATA_WIDTH-1:0] perm_data;
  logic                  fwd_mode;
  logic                  accept;
  logic                  drain;

`ifdef INV_SHIFT_ROW_FWD_EN
  assign fwd_mode = invShiftRow_fwd_mode;
`else
  assign fwd_mode = 1'b0;
`endif

  // Permute before storage so the mode is bound to its beat at acceptance.
  inv_shift_row_perm u_perm (
    .fwd_mode_i (fwd_mode),
    .data_i     (invShiftRow_data_in),
    .data_o     (perm_data)
  );

  always_comb begin
    invShiftRow_ready_in  = ~sk_valid_q;
    invShiftRow_valid_out = or_valid_q;
    invShiftRow_data_out  = or_data_q;
    accept = invShiftRow_valid_in & ~sk_valid_q;
    drain  = or_valid_q & invShiftRow_ready_out;
  end

  always_comb begin
    or_valid_d = or_valid_q;
    or_data_d  = or_data_q;
    sk_valid_d = sk_valid_q;
    sk_data_d  = sk_data_q;
    if (drain) begin
      if (sk_valid_q) begin
        // ready_in is low whenever SK is full, so no accept can coincide here.
        or_data_d  = sk_data_q;
        sk_valid_d = 1'b0;
      end else if (accept) begin
        or_data_d = perm_data;
      end else begin
        or_valid_d = 1'b0;
      end
    end else if (accept) begin
      if (or_valid_q) begin
        sk_valid_d = 1'b1;
        sk_data_d  = perm_data;
      end else begin
        or_valid_d = 1'b1;
        or_data_d  = perm_data;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      or_valid_q <= 1'b0;
      sk_valid_q <= 1'b0;
      or_data_q  <= '0;
      sk_data_q  <= '0;
    end else begin
      or_valid_q <= or_valid_d;
      sk_valid_q <= sk_valid_d;
      or_data_q  <= or_data_d;
      sk_data_q  <= sk_data_d;
    end
  end

endmodule

// File: tb/tb_inv_shift_row.sv
// Self-checking bench for inv_shift_row: vector table, queue-based reference model, corner cases.
module tb_inv_shift_row;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         valid_in;
  logic         ready_in;
  logic [127:0] data_in;
  logic [127:0] data_out;
  logic         valid_out;
  logic         ready_out;
`ifdef INV_SHIFT_ROW_FWD_EN
  logic         fwd_mode;
  localparam bit FwdEn = 1'b1;
`else
  localparam bit FwdEn = 1'b0;
`endif

  int total = 0;
  int bad   = 0;

  logic [127:0] exp_q [$];
  logic [127:0] last_shown = '0;

  typedef struct {
    logic [127:0] din;
    bit           mode;
    logic [127:0] dout;
  } vec_t;
  vec_t vecs [$];

  always #5 clk = ~clk;

  inv_shift_row dut (
    .clk                   (clk),
    .rst_n                 (rst_n),
    .invShiftRow_valid_in  (valid_in),
    .invShiftRow_ready_in  (ready_in),
    .invShiftRow_data_in   (data_in),
    .invShiftRow_data_out  (data_out),
    .invShiftRow_valid_out (valid_out),
`ifdef INV_SHIFT_ROW_FWD_EN
    .invShiftRow_fwd_mode  (fwd_mode),
`endif
    .invShiftRow_ready_out (ready_out)
  );

  // State as a 4x4 byte matrix; row r of column c comes from column (c -/+ r) mod 4.
  function automatic logic [127:0] ref_perm(input logic [127:0] s, input bit fwd);
    logic [7:0]   b [16];
    logic [127:0] o;
    int           src;
    for (int k = 0; k < 16; k++) b[k] = s[127-8*k -: 8];
    o = '0;
    for (int c = 0; c < 4; c++) begin
      for (int r = 0; r < 4; r++) begin
        src = fwd ? r + 4 * ((c + r) % 4) : r + 4 * ((c - r + 4) % 4);
        o[127-8*(r+4*c) -: 8] = b[src];
      end
    end
    return o;
  endfunction

  function automatic logic [127:0] rnd128();
    return {$urandom(), $urandom(), $urandom(), $urandom()};
  endfunction

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s: got %h want %h", name, act, req);
    end
  endtask

  // One clock: drive inputs, step the model at the edge, compare outputs 1ns later.
  task automatic cycle(input bit v, input logic [127:0] d, input bit ro, input bit m);
    bit acc;
    bit drn;
    valid_in  = v;
    data_in   = d;
    ready_out = ro;
`ifdef INV_SHIFT_ROW_FWD_EN
    fwd_mode  = m;
`endif
    chk("ready_in", 128'(ready_in), 128'(exp_q.size() < 2));
    @(posedge clk);
    acc = v && (exp_q.size() < 2);
    drn = ro && (exp_q.size() > 0);
    if (drn) void'(exp_q.pop_front());
    if (acc) exp_q.push_back(ref_perm(d, FwdEn && m));
    #1;
    chk("valid_out", 128'(valid_out), 128'(exp_q.size() > 0));
    if (exp_q.size() > 0) last_shown = exp_q[0];
    chk("data_out", data_out, last_shown);
  endtask

  initial begin
    vecs.push_back('{128'h000102030405060708090a0b0c0d0e0f, 1'b0,
                     128'h000d0a0704010e0b0805020f0c090603});
    vecs.push_back('{128'h0, 1'b0, 128'h0});
    vecs.push_back('{128'h00112233445566778899aabbccddeeff, 1'b0,
                     128'h00ddaa774411eebb885522ffcc996633});
    vecs.push_back('{128'h0f0e0d0c0b0a09080706050403020100, 1'b0,
                     128'h0f0205080b0e0104070a0d000306090c});
`ifdef INV_SHIFT_ROW_FWD_EN
    vecs.push_back('{128'h000d0a0704010e0b0805020f0c090603, 1'b1,
                     128'h000102030405060708090a0b0c0d0e0f});
    vecs.push_back('{128'h000102030405060708090a0b0c0d0e0f, 1'b1,
                     128'h00050a0f04090e03080d02070c01060b});
    fwd_mode = 1'b0;
`endif

    // Reset with valid_in held high
    rst_n     = 1'b0;
    valid_in  = 1'b1;
    data_in   = rnd128();
    ready_out = 1'b1;
    #3;
    chk("rst_valid_out", 128'(valid_out), 128'(0));
    chk("rst_data_out", data_out, 128'h0);
    chk("rst_ready_in", 128'(ready_in), 128'(1));
    #5;
    chk("rst_edge_valid_out", 128'(valid_out), 128'(0));
    #4 rst_n = 1'b1;
    #1;
    chk("rel_ready_in", 128'(ready_in), 128'(1));

    // Table-driven single beats
    foreach (vecs[i]) begin
      cycle(1'b1, vecs[i].din, 1'b1, vecs[i].mode);
      chk("vec_out", data_out, vecs[i].dout);
      chk("vec_valid", 128'(valid_out), 128'(1));
      cycle(1'b0, rnd128(), 1'b1, 1'b0);
      chk("vec_one_cycle", 128'(valid_out), 128'(0));
    end

    // Streaming: 16 back-to-back beats
    for (int i = 0; i < 16; i++) cycle(1'b1, rnd128(), 1'b1, 1'b0);
    cycle(1'b0, rnd128(), 1'b1, 1'b0);

    // Back-pressure: 4 beats offered during 5 stalled cycles
    for (int i = 0; i < 5; i++) cycle(i < 4, rnd128(), 1'b0, 1'b0);
    chk("bp_ready_in", 128'(ready_in), 128'(0));
    chk("bp_occupancy", 128'(exp_q.size()), 128'(2));
    for (int i = 0; i < 3; i++) cycle(1'b0, rnd128(), 1'b1, 1'b0);

    // Asynchronous reset while OR and SK are both full
    cycle(1'b1, rnd128(), 1'b0, 1'b0);
    cycle(1'b1, rnd128(), 1'b0, 1'b0);
    #2 rst_n = 1'b0;
    #1;
    chk("midrst_valid_out", 128'(valid_out), 128'(0));
    chk("midrst_data_out", data_out, 128'h0);
    chk("midrst_ready_in", 128'(ready_in), 128'(1));
    exp_q.delete();
    last_shown = '0;
    #1 rst_n = 1'b1;
    for (int i = 0; i < 3; i++) cycle(1'b0, rnd128(), 1'b1, 1'b0);

`ifdef INV_SHIFT_ROW_FWD_EN
    // Mode alternating per beat, with and without stalls
    for (int i = 0; i < 8; i++) cycle(1'b1, rnd128(), 1'b1, i[0]);
    for (int i = 0; i < 8; i++) cycle(1'b1, rnd128(), i[1], i[0]);
    for (int i = 0; i < 3; i++) cycle(1'b0, rnd128(), 1'b1, 1'b0);
`endif

    // Random traffic against the reference model
    for (int i = 0; i < 300; i++) begin
      cycle(($urandom % 4) != 0, rnd128(), ($urandom % 3) != 0, $urandom_range(0, 1) == 1);
    end
    for (int i = 0; i < 3; i++) cycle(1'b0, rnd128(), 1'b1, 1'b0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
